// File: rtl/vga_timing_rx_if.sv
// vga_timing_rx_if: bundles the raw VGA timing inputs with the recovered coordinates and lock status.
// Latency: n/a (wires only).
// Backpressure: none; the timing stream is free-running.
// Ports: master drives hsync/vsync/blank and observes the recovered outputs; slave is the receiver.
interface vga_timing_rx_if;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [10:0] x;
    logic [9:0]  y;
    logic        de;
    logic        line_start;
    logic        frame_start;
    logic [10:0] h_total;
    logic [9:0]  v_total;
    logic        locked;
    logic        lock_lost;

    modport master (
        output hsync, vsync, blank,
        input  x, y, de, line_start, frame_start, h_total, v_total, locked, lock_lost
    );

    modport slave (
        input  hsync, vsync, blank,
        output x, y, de, line_start, frame_start, h_total, v_total, locked, lock_lost
    );
endinterface

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: VGA timing sink; recovers pixel x/y, measures line/frame length, tracks lock.
// Latency: 2 clk from hsync/vsync/blank at the pins to x/y/de/pulses/lock outputs.
// Backpressure: none; one pixel is consumed every clock.
// Ports: clk, reset_n (async active-low); vif (slave) carries hsync/vsync/blank in and
//        x, y, de, line_start, frame_start, h_total, v_total, locked, lock_lost out.
module vga_timing_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    vga_timing_rx_if.slave vif
);
    localparam logic [10:0] H_EXP  = 11'(H_TOTAL);
    localparam logic [9:0]  V_EXP  = 10'(V_TOTAL);
    localparam logic [11:0] TO_LIM = 12'(2 * H_TOTAL);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [10:0] X_MAX  = 11'h7FF;
    localparam logic [9:0]  Y_MAX  = 10'h3FF;

    typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [3:0]  good_cnt, good_cnt_nxt;
    logic        lost_nxt;

    logic        hs_s1, hs_s2, vs_s1, vs_s2, bl_s1, bl_s2;
    logic [10:0] hcnt, x_q, h_total_q;
    logic [9:0]  vcnt, y_q, v_total_q;
    logic        meas_valid, line_err, vsync_seen, to_done;
    logic        de_q, line_start_q, frame_start_q, locked_q, lock_lost_q;

    logic        hs_fall, vs_fall, bl_fall;
    logic        line_bad, frame_eval, frame_good, timeout;

    assign hs_fall    = ~hs_s1 & hs_s2;
    assign vs_fall    = ~vs_s1 & vs_s2;
    assign bl_fall    = ~bl_s1 & bl_s2;
    // A bad line closing in the same clock as the vsync fall still belongs to the ending frame.
    assign line_bad   = hs_fall & meas_valid & (hcnt != H_EXP);
    assign frame_eval = vs_fall & meas_valid;
    assign frame_good = (vcnt == V_EXP) & ~line_err & ~line_bad;
    // Sync lost: no hsync fall for two nominal lines; to_done keeps it to one event per gap.
    assign timeout    = ~hs_fall & ~to_done & ({1'b0, hcnt} >= TO_LIM);

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        lost_nxt     = 1'b0;
        if (timeout) begin
            state_nxt    = SEARCH;
            good_cnt_nxt = 4'd0;
            lost_nxt     = (state == LOCKED);
        end else if (frame_eval) begin
            case (state)
                SEARCH: begin
                    if (frame_good) begin
                        good_cnt_nxt = 4'd1;
                        state_nxt    = (LOCK_N <= 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (frame_good) begin
                        good_cnt_nxt = good_cnt + 4'd1;
                        if (good_cnt_nxt >= LOCK_N) state_nxt = LOCKED;
                    end else begin
                        good_cnt_nxt = 4'd0;
                        state_nxt    = SEARCH;
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        good_cnt_nxt = 4'd0;
                        state_nxt    = SEARCH;
                        lost_nxt     = 1'b1;
                    end
                end
                default: begin
                    good_cnt_nxt = 4'd0;
                    state_nxt    = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEARCH;
            good_cnt    <= 4'd0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_cnt_nxt;
            locked_q    <= (state_nxt == LOCKED);
            lock_lost_q <= lost_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_s1 <= 1'b0;  hs_s2 <= 1'b0;
            vs_s1 <= 1'b0;  vs_s2 <= 1'b0;
            // Blank resets high so nothing reads as visible before the first real sample.
            bl_s1 <= 1'b1;  bl_s2 <= 1'b1;
            hcnt          <= '0;
            vcnt          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            meas_valid    <= 1'b0;
            line_err      <= 1'b0;
            vsync_seen    <= 1'b0;
            to_done       <= 1'b0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hs_s1 <= vif.hsync;  hs_s2 <= hs_s1;
            vs_s1 <= vif.vsync;  vs_s2 <= vs_s1;
            bl_s1 <= vif.blank;  bl_s2 <= bl_s1;

            de_q          <= ~bl_s1;
            line_start_q  <= hs_fall;
            frame_start_q <= vs_fall;

            if (bl_fall)                      x_q <= '0;
            else if (!bl_s1 && x_q != X_MAX)  x_q <= x_q + 11'd1;

            if (bl_fall) begin
                if (vsync_seen)          y_q <= '0;
                else if (y_q != Y_MAX)   y_q <= y_q + 10'd1;
            end
            if (vs_fall)      vsync_seen <= 1'b1;
            else if (bl_fall) vsync_seen <= 1'b0;

            if (hs_fall) begin
                h_total_q <= hcnt;
                hcnt      <= 11'd1;
            end else if (hcnt != X_MAX) begin
                hcnt <= hcnt + 11'd1;
            end

            // An hsync fall coinciding with the vsync fall opens the new frame's line count.
            if (vs_fall) begin
                v_total_q <= vcnt;
                vcnt      <= hs_fall ? 10'd1 : 10'd0;
            end else if (hs_fall && vcnt != Y_MAX) begin
                vcnt <= vcnt + 10'd1;
            end

            if (vs_fall)       line_err <= 1'b0;
            else if (line_bad) line_err <= 1'b1;

            if (timeout)      meas_valid <= 1'b0;
            else if (vs_fall) meas_valid <= 1'b1;

            if (hs_fall)      to_done <= 1'b0;
            else if (timeout) to_done <= 1'b1;
        end
    end

    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.de          = de_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.h_total     = h_total_q;
    assign vif.v_total     = v_total_q;
    assign vif.locked      = locked_q;
    assign vif.lock_lost   = lock_lost_q;
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: drives reduced-size VGA timing (40x20 total, 32x15 visible) into two receivers
// (lock after 2 frames and after 1 frame) and checks them against an event-level reference model.
// Backpressure: none.
`timescale 1ns/1ps
module tb_vga_timing_rx;
    localparam int HT = 40, VT = 20, HV = 32, VV = 15;
    localparam int HS0 = 33, HS1 = 37, VS0 = 17, VS1 = 19;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic hs = 1'b1, vs = 1'b1, bl = 1'b1;
    always #5 clk = ~clk;

    vga_timing_rx_if vif_a ();
    vga_timing_rx_if vif_b ();
    assign vif_a.hsync = hs;  assign vif_a.vsync = vs;  assign vif_a.blank = bl;
    assign vif_b.hsync = hs;  assign vif_b.vsync = vs;  assign vif_b.blank = bl;

    vga_timing_rx #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .vif(vif_a));
    vga_timing_rx #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .vif(vif_b));

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard of visible pixels; chk=0 means coordinates are not yet defined (no vsync seen).
    typedef struct packed {logic chk; logic [10:0] x; logic [9:0] y;} px_t;
    px_t sb_q[$];
    int ls_cnt = 0, fs_cnt = 0, lost_a = 0, lost_b = 0;

    initial begin
        px_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                if (vif_a.line_start)  ls_cnt++;
                if (vif_a.frame_start) fs_cnt++;
                if (vif_a.lock_lost)   lost_a++;
                if (vif_b.lock_lost)   lost_b++;
                if (vif_a.de) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL de_unexpected: de=1 with no visible pixel driven (x=%0d y=%0d)",
                                 vif_a.x, vif_a.y);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.chk) begin
                            check("pix_x", vif_a.x, e.x);
                            check("pix_y", vif_a.y, e.y);
                        end
                    end
                end
            end
        end
    end

    // Reference model: operates on the driven waveform, one call per pixel clock.
    bit prev_hs, prev_vs, mvalid, ivbad, frame_known;
    int gap, ivlines, last_gap, last_vtot, exp_ls = 0, exp_fs = 0;
    int run[2];
    bit mlock[2];
    int mlost[2];

    function automatic int lf(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic model_frame(input bit good);
        for (int i = 0; i < 2; i++) begin
            if (good) begin
                run[i]++;
                if (run[i] >= lf(i)) mlock[i] = 1'b1;
            end else begin
                if (mlock[i]) mlost[i]++;
                mlock[i] = 1'b0;
                run[i]   = 0;
            end
        end
    endtask

    task automatic model_timeout();
        for (int i = 0; i < 2; i++) begin
            if (mlock[i]) mlost[i]++;
            mlock[i] = 1'b0;
            run[i]   = 0;
        end
        mvalid = 1'b0;
    endtask

    task automatic model_reset();
        prev_hs = 1'b0;  prev_vs = 1'b0;
        mvalid = 1'b0;   ivbad = 1'b0;   frame_known = 1'b0;
        gap = 0;  ivlines = 0;  last_gap = 0;  last_vtot = 0;
        for (int i = 0; i < 2; i++) begin
            run[i] = 0;
            mlock[i] = 1'b0;
        end
    endtask

    task automatic drive_px(input logic h_s, input logic v_s, input logic b_s, input int px, input int py);
        bit hf, vf, hbad;
        @(negedge clk);
        hs = h_s;  vs = v_s;  bl = b_s;
        hf = prev_hs && !h_s;
        vf = prev_vs && !v_s;
        prev_hs = h_s;
        prev_vs = v_s;
        gap++;
        hbad = hf && mvalid && (gap != HT);
        if (hf) begin
            last_gap = gap;
            gap = 0;
            exp_ls++;
        end
        if (vf) begin
            exp_fs++;
            last_vtot = ivlines;
            if (mvalid) model_frame((ivlines == VT) && !ivbad && !hbad);
            mvalid = 1'b1;
            ivbad = 1'b0;
            ivlines = hf ? 1 : 0;
            frame_known = 1'b1;
        end else begin
            if (hbad) ivbad = 1'b1;
            if (hf) ivlines++;
            if (!hf && gap == 2 * HT) model_timeout();
        end
        if (!b_s) sb_q.push_back({frame_known, 11'(px), 10'(py)});
    endtask

    task automatic frame_checks();
        check("locked_a", vif_a.locked, mlock[0]);
        check("locked_b", vif_b.locked, mlock[1]);
        check("lock_lost_a_count", lost_a, mlost[0]);
        check("lock_lost_b_count", lost_b, mlost[1]);
        check("h_total", vif_a.h_total, last_gap);
        check("v_total", vif_a.v_total, last_vtot);
        check("line_start_count", ls_cnt, exp_ls);
        check("frame_start_count", fs_cnt, exp_fs);
    endtask

    task automatic drive_frame(input int nlines, input int bad_v, input int bad_len);
        int len;
        for (int v = 0; v < nlines; v++) begin
            len = (v == bad_v) ? bad_len : HT;
            if (v == VS0 - 1) begin
                // Lock only changes at vsync falls, so mid-frame it must still reflect the last one.
                check("locked_mid_a", vif_a.locked, mlock[0]);
                check("locked_mid_b", vif_b.locked, mlock[1]);
            end
            for (int h = 0; h < len; h++)
                drive_px(!(h >= HS0 && h < HS1), !(v >= VS0 && v < VS1), (h >= HV) || (v >= VV), h, v);
        end
        frame_checks();
    endtask

    task automatic drive_idle(input int n);
        frame_known = 1'b0;
        for (int i = 0; i < n; i++) drive_px(1'b1, 1'b1, 1'b1, 0, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_a"}, {vif_a.x, vif_a.y, vif_a.de, vif_a.line_start, vif_a.frame_start,
                             vif_a.h_total, vif_a.v_total, vif_a.locked, vif_a.lock_lost}, 0);
        check({name, "_b"}, {vif_b.x, vif_b.y, vif_b.de, vif_b.line_start, vif_b.frame_start,
                             vif_b.h_total, vif_b.v_total, vif_b.locked, vif_b.lock_lost}, 0);
    endtask

    int kind, bv, blen, nl;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset_n = 1'b1;

        // Initial lock and a steady locked stream (coordinates scoreboarded throughout).
        drive_frame(VT, -1, HT);
        drive_frame(VT, -1, HT);
        drive_frame(VT, -1, HT);
        check("lock_at_third_vsync", vif_a.locked, 1);
        drive_frame(VT, -1, HT);
        drive_frame(VT, -1, HT);

        // One long line: lock held until this frame's vsync fall, then relock after two good frames.
        drive_frame(VT, 5, HT + 1);
        check("long_line_unlocks", vif_a.locked, 0);
        drive_frame(VT, -1, HT);
        check("long_line_verify", vif_a.locked, 0);
        drive_frame(VT, -1, HT);
        check("long_line_relock", vif_a.locked, 1);

        // One frame with an extra line: single-frame receiver relocks one frame before the other.
        drive_frame(VT + 1, -1, HT);
        drive_frame(VT, -1, HT);
        check("extra_line_v_total", vif_a.v_total, VT + 1);
        check("extra_line_unlock_a", vif_a.locked, 0);
        drive_frame(VT, -1, HT);
        check("extra_line_relock_b", vif_b.locked, 1);
        check("extra_line_verify_a", vif_a.locked, 0);
        drive_frame(VT, -1, HT);
        check("extra_line_relock_a", vif_a.locked, 1);

        // Randomized mix of good frames, bad line lengths and wrong line counts.
        for (int i = 0; i < 12; i++) begin
            kind = $urandom_range(0, 3);
            if (kind == 2) begin
                bv   = $urandom_range(0, VS0 - 2);
                blen = HT + ($urandom_range(0, 1) ? 1 : -1) * $urandom_range(1, 2);
                drive_frame(VT, bv, blen);
            end else if (kind == 3) begin
                nl = $urandom_range(0, 1) ? VT + 1 : VT - 1;
                drive_frame(nl, -1, HT);
            end else begin
                drive_frame(VT, -1, HT);
            end
        end
        repeat (4) drive_frame(VT, -1, HT);
        check("locked_before_timeout", vif_a.locked, 1);

        // Loss of hsync: still locked just short of two nominal lines, unlocked once beyond.
        drive_idle(70);
        check("timeout_not_early_a", vif_a.locked, mlock[0]);
        check("timeout_not_early_lost", lost_a, mlost[0]);
        drive_idle(30);
        check("timeout_unlock", vif_a.locked, 0);
        frame_checks();
        repeat (4) drive_frame(VT, -1, HT);

        // Asynchronous reset in the middle of a visible line while locked.
        for (int v = 0; v < 5; v++)
            for (int h = 0; h < HT; h++)
                drive_px(!(h >= HS0 && h < HS1), 1'b1, (h >= HV), h, v);
        for (int h = 0; h <= 20; h++) drive_px(1'b1, 1'b1, 1'b0, h, 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        hs = 1'b1;  vs = 1'b1;  bl = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        sb_q.delete();
        reset_n = 1'b1;
        drive_frame(VT, -1, HT);
        drive_frame(VT, -1, HT);
        check("reset_relock_wait_a", vif_a.locked, 0);
        drive_frame(VT, -1, HT);
        drive_frame(VT, -1, HT);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
